// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS bus interface unit.
//   bus_state_t : bus-side FSM encoding (IDLE, WR, RD, GAP)
//   RW_READ/RW_WRITE : encoding of the core and bus read/write strobes
//   clog2 : ceiling log2 used to size pointers and counters
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_GAP  = 2'd3
    } bus_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_wb_fifo.sv
// Posted-write buffer: synchronous FIFO with first-word-fall-through head.
//   Clk, Reset       : clock, asynchronous active-high reset
//   Push_I, Data_I   : write an entry (caller guarantees room, or a pop in the same cycle)
//   Pop_I            : discard the head entry (caller guarantees non-empty)
//   Full_O, Empty_O  : occupancy flags
//   Count_O          : number of stored entries
//   Head_O           : oldest entry, valid while Empty_O = 0
module mips_wb_fifo
    import mips_bus_pkg::*;
#(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Push_I,
    input  logic                   Pop_I,
    input  logic [WIDTH-1:0]       Data_I,
    output logic                   Full_O,
    output logic                   Empty_O,
    output logic [clog2(DEPTH):0]  Count_O,
    output logic [WIDTH-1:0]       Head_O
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count decide which entries are valid, so clearing data buys nothing.
    always_ff @(posedge Clk) begin
        if (Push_I) begin
            r_mem[r_wr_ptr] <= Data_I;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (Push_I) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (Pop_I) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({Push_I, Pop_I})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign Full_O  = (r_count == CW'(DEPTH));
    assign Empty_O = (r_count == '0);
    assign Count_O = r_count;
    assign Head_O  = r_mem[r_rd_ptr];

endmodule

// File: rtl/mips_bus_iface_unit.sv
// Bus interface unit between the MIPS core memory port and the system bus.
// Writes are posted into a buffer and drained in order; reads wait until the
// buffer is drained and the bus is idle. A bus wait longer than TIMEOUT
// cycles aborts the transfer (TIMEOUT = 0 disables the abort).
//   Clk, Reset          : clock, asynchronous active-high reset
//   Core_*              : core request/response port (request held until Core_Ack_O)
//   Bus_*               : system bus master port
//   Wb_Empty_O          : buffer empty and bus idle (SYNC / exception entry)
//   Wb_Err_O, Err_Clr_I : sticky buffered-write timeout flag and its clear
module mips_bus_iface_unit
    import mips_bus_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WB_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Core_Req_I,
    input  logic            Core_RW_I,
    input  logic [AW-1:0]   Core_Addr_I,
    input  logic [DW-1:0]   Core_Data_I,
    input  logic [DW/8-1:0] Core_BE_I,
    output logic            Core_Ack_O,
    output logic [DW-1:0]   Core_Data_O,
    output logic            Core_BusErr_O,
    output logic            Bus_Req_O,
    output logic            Bus_RW_O,
    output logic [AW-1:0]   Bus_Addr_O,
    output logic [DW-1:0]   Bus_Data_O,
    output logic [DW/8-1:0] Bus_BE_O,
    input  logic [DW-1:0]   Bus_Data_I,
    input  logic            Bus_Ack_I,
    output logic            Wb_Empty_O,
    output logic            Wb_Err_O,
    input  logic            Err_Clr_I
);

    localparam int BW = DW / 8;
    localparam int EW = AW + DW + BW;
    localparam int CW = clog2(WB_DEPTH) + 1;
    localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    // The abort fires in the cycle whose increment would reach TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    bus_state_t      r_state;
    bus_state_t      w_state_nxt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [AW-1:0]   r_rd_addr;
    logic [BW-1:0]   r_rd_be;
    logic            r_core_ack;
    logic [DW-1:0]   r_core_data;
    logic            r_core_berr;
    logic            r_wb_err;

    logic            w_req_sample;
    logic            w_wr_req;
    logic            w_rd_req;
    logic            w_bus_busy;
    logic            w_timeout;
    logic            w_push;
    logic            w_pop;
    logic            w_rd_done;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic [EW-1:0]   w_fifo_head;
    logic [EW-1:0]   w_push_data;

    // A request is only seen while no ack is in flight, so the held request
    // is never taken twice and acks can never be back to back.
    assign w_req_sample = Core_Req_I && !r_core_ack;
    assign w_wr_req     = w_req_sample && (Core_RW_I == RW_WRITE);
    assign w_rd_req     = w_req_sample && (Core_RW_I == RW_READ);
    assign w_bus_busy   = (r_state == ST_WR) || (r_state == ST_RD);

    // Ack has priority over an abort landing in the same cycle.
    assign w_timeout = (TIMEOUT != 0) && w_bus_busy && !Bus_Ack_I && (r_tmo_cnt == TMO_LAST);

    assign w_pop     = (r_state == ST_WR) && (Bus_Ack_I || w_timeout);
    assign w_rd_done = (r_state == ST_RD) && (Bus_Ack_I || w_timeout);
    // A full buffer still accepts when the head leaves in the same cycle.
    assign w_push    = w_wr_req && (!w_fifo_full || w_pop);

    assign w_push_data = {Core_Addr_I, Core_Data_I, Core_BE_I};

    mips_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .Push_I  (w_push),
        .Pop_I   (w_pop),
        .Data_I  (w_push_data),
        .Full_O  (w_fifo_full),
        .Empty_O (w_fifo_empty),
        .Count_O (w_fifo_count),
        .Head_O  (w_fifo_head)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: buffered writes drain before any read is issued.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_WR;
                end else if (w_rd_req) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_WR, ST_RD: begin
                if (Bus_Ack_I || w_timeout) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are pure decodes of the state plus stable sources (buffer
    // head, latched read address), so they hold while Bus_Req_O is high.
    always_comb begin
        Bus_Req_O  = 1'b0;
        Bus_RW_O   = RW_WRITE;
        Bus_Addr_O = '0;
        Bus_Data_O = '0;
        Bus_BE_O   = '0;
        case (r_state)
            ST_WR: begin
                Bus_Req_O  = 1'b1;
                Bus_RW_O   = RW_WRITE;
                Bus_Addr_O = w_fifo_head[EW-1 -: AW];
                Bus_Data_O = w_fifo_head[BW +: DW];
                Bus_BE_O   = w_fifo_head[0 +: BW];
            end
            ST_RD: begin
                Bus_Req_O  = 1'b1;
                Bus_RW_O   = RW_READ;
                Bus_Addr_O = r_rd_addr;
                Bus_BE_O   = r_rd_be;
            end
            default: ;
        endcase
    end

    // Timeout counter: held at zero outside WR/RD, so it starts at zero on entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tmo_cnt <= '0;
        end else if (!w_bus_busy) begin
            r_tmo_cnt <= '0;
        end else if (!Bus_Ack_I) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Core response registers, read address capture and sticky write error.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rd_addr   <= '0;
            r_rd_be     <= '0;
            r_core_ack  <= 1'b0;
            r_core_data <= '0;
            r_core_berr <= 1'b0;
            r_wb_err    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_RD)) begin
                r_rd_addr <= Core_Addr_I;
                r_rd_be   <= Core_BE_I;
            end
            r_core_ack  <= w_push || w_rd_done;
            r_core_data <= ((r_state == ST_RD) && Bus_Ack_I) ? Bus_Data_I : '0;
            r_core_berr <= w_rd_done && !Bus_Ack_I;
            // A new timeout outranks a clear requested in the same cycle.
            if ((r_state == ST_WR) && w_timeout) begin
                r_wb_err <= 1'b1;
            end else if (Err_Clr_I) begin
                r_wb_err <= 1'b0;
            end
        end
    end

    assign Core_Ack_O    = r_core_ack;
    assign Core_Data_O   = r_core_data;
    assign Core_BusErr_O = r_core_berr;
    assign Wb_Err_O      = r_wb_err;
    assign Wb_Empty_O    = (w_fifo_count == '0) && (r_state == ST_IDLE);

endmodule

// File: tb/tb_mips_bus_iface_unit.sv
// Directed bench for mips_bus_iface_unit (WB_DEPTH=4, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mips_bus_iface_unit;

    logic        Clk;
    logic        Reset;
    logic        Core_Req_I;
    logic        Core_RW_I;
    logic [31:0] Core_Addr_I;
    logic [31:0] Core_Data_I;
    logic [3:0]  Core_BE_I;
    logic        Core_Ack_O;
    logic [31:0] Core_Data_O;
    logic        Core_BusErr_O;
    logic        Bus_Req_O;
    logic        Bus_RW_O;
    logic [31:0] Bus_Addr_O;
    logic [31:0] Bus_Data_O;
    logic [3:0]  Bus_BE_O;
    logic [31:0] Bus_Data_I;
    logic        Bus_Ack_I;
    logic        Wb_Empty_O;
    logic        Wb_Err_O;
    logic        Err_Clr_I;

    int n_checks;
    int n_fail;

    mips_bus_iface_unit #(
        .AW       (32),
        .DW       (32),
        .WB_DEPTH (4),
        .TIMEOUT  (8)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Core_Req_I    (Core_Req_I),
        .Core_RW_I     (Core_RW_I),
        .Core_Addr_I   (Core_Addr_I),
        .Core_Data_I   (Core_Data_I),
        .Core_BE_I     (Core_BE_I),
        .Core_Ack_O    (Core_Ack_O),
        .Core_Data_O   (Core_Data_O),
        .Core_BusErr_O (Core_BusErr_O),
        .Bus_Req_O     (Bus_Req_O),
        .Bus_RW_O      (Bus_RW_O),
        .Bus_Addr_O    (Bus_Addr_O),
        .Bus_Data_O    (Bus_Data_O),
        .Bus_BE_O      (Bus_BE_O),
        .Bus_Data_I    (Bus_Data_I),
        .Bus_Ack_I     (Bus_Ack_I),
        .Wb_Empty_O    (Wb_Empty_O),
        .Wb_Err_O      (Wb_Err_O),
        .Err_Clr_I     (Err_Clr_I)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Present a core write and wait (bounded) for its ack; cyc = cycles taken.
    task automatic write_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input int max_cyc, output int cyc);
        Core_Req_I  = 1'b1;
        Core_RW_I   = 1'b0;
        Core_Addr_I = a;
        Core_Data_I = d;
        Core_BE_I   = be;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!Core_Ack_O && cyc < max_cyc);
        Core_Req_I = 1'b0;
    endtask

    // Act as the bus target: wait for a request, check it, ack after 'delay' cycles.
    task automatic bus_serve(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic rw, input int delay,
                             input logic [31:0] rdata);
        int w;
        w = 0;
        while (!Bus_Req_O && w < 20) begin
            @(negedge Clk);
            w++;
        end
        n_checks++;
        if (Bus_Req_O !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_req: no bus request within 20 cycles", name);
        end
        n_checks++;
        if ({Bus_RW_O, Bus_Addr_O, Bus_BE_O} !== {rw, a, be}) begin
            n_fail++;
            $display("FAIL %s_cmd: got rw=%b addr=%h be=%h exp rw=%b addr=%h be=%h",
                     name, Bus_RW_O, Bus_Addr_O, Bus_BE_O, rw, a, be);
        end
        if (rw == 1'b0) begin
            n_checks++;
            if (Bus_Data_O !== d) begin
                n_fail++;
                $display("FAIL %s_wdata: got %h exp %h", name, Bus_Data_O, d);
            end
        end
        repeat (delay) @(negedge Clk);
        n_checks++;
        if ({Bus_Req_O, Bus_Addr_O} !== {1'b1, a}) begin
            n_fail++;
            $display("FAIL %s_hold: got req=%b addr=%h exp req=1 addr=%h", name, Bus_Req_O, Bus_Addr_O, a);
        end
        Bus_Data_I = rdata;
        Bus_Ack_I  = 1'b1;
        @(negedge Clk);
        Bus_Ack_I  = 1'b0;
    endtask

    // Bounded wait for the unit to go idle; a miss counts as a failure.
    task automatic wait_empty(input string name);
        int w;
        w = 0;
        while (!Wb_Empty_O && w < 40) begin
            @(negedge Clk);
            w++;
        end
        n_checks++;
        if (Wb_Empty_O !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_empty: got %b exp 1", name, Wb_Empty_O);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge Clk);
        n_checks++;
        if ({Core_Ack_O, Core_BusErr_O, Bus_Req_O, Bus_RW_O, Wb_Err_O, Wb_Empty_O} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_flags: got ack=%b berr=%b req=%b rw=%b err=%b empty=%b exp 000001",
                     Core_Ack_O, Core_BusErr_O, Bus_Req_O, Bus_RW_O, Wb_Err_O, Wb_Empty_O);
        end
        n_checks++;
        if ({Core_Data_O, Bus_Addr_O, Bus_Data_O, Bus_BE_O} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: got cdata=%h addr=%h bdata=%h be=%h exp all 0",
                     Core_Data_O, Bus_Addr_O, Bus_Data_O, Bus_BE_O);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_single_write();
        int cyc;
        write_req(32'h100, 32'hDEADBEEF, 4'hF, 5, cyc);
        n_checks++;
        if (cyc !== 1 || Core_Ack_O !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_ack: got %0d cycles ack=%b exp 1 cycle ack=1", cyc, Core_Ack_O);
        end
        n_checks++;
        if (Wb_Empty_O !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_not_empty: got %b exp 0", Wb_Empty_O);
        end
        bus_serve("sw", 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1, 32'h0);
        n_checks++;
        if ({Bus_Req_O, Core_Ack_O} !== 2'b00) begin
            n_fail++;
            $display("FAIL sw_gap: got req=%b ack=%b exp 00", Bus_Req_O, Core_Ack_O);
        end
        wait_empty("sw");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr [5];
        logic [31:0] data [5];
        logic [3:0]  be   [5];
        int cyc;
        addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
        data = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
        be   = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h8};
        for (int i = 0; i < 4; i++) begin
            write_req(addr[i], data[i], be[i], 6, cyc);
            n_checks++;
            if (cyc !== ((i == 0) ? 1 : 2) || Core_Ack_O !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ack%0d: got %0d cycles ack=%b exp %0d cycles ack=1",
                         i, cyc, Core_Ack_O, (i == 0) ? 1 : 2);
            end
        end
        // Fifth write meets a full buffer while the bus holds entry 0 unacked.
        Core_Req_I  = 1'b1;
        Core_RW_I   = 1'b0;
        Core_Addr_I = addr[4];
        Core_Data_I = data[4];
        Core_BE_I   = be[4];
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({Core_Ack_O, Bus_Req_O, Bus_Addr_O} !== {1'b0, 1'b1, addr[0]}) begin
            n_fail++;
            $display("FAIL b2b_stall: got ack=%b req=%b addr=%h exp ack=0 req=1 addr=%h",
                     Core_Ack_O, Bus_Req_O, Bus_Addr_O, addr[0]);
        end
        // This ack lands in the 8th bus-wait cycle: success, not timeout.
        Bus_Ack_I = 1'b1;
        @(negedge Clk);
        Bus_Ack_I  = 1'b0;
        Core_Req_I = 1'b0;
        n_checks++;
        if ({Core_Ack_O, Bus_Req_O, Wb_Err_O} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_fifth: got ack=%b req=%b err=%b exp 100", Core_Ack_O, Bus_Req_O, Wb_Err_O);
        end
        for (int i = 1; i < 5; i++) begin
            bus_serve($sformatf("b2b_drain%0d", i), addr[i], data[i], be[i], 1'b0, 0, 32'h0);
        end
        wait_empty("b2b");
        n_checks++;
        if (Wb_Err_O !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err: got %b exp 0", Wb_Err_O);
        end
    endtask

    task automatic test_read_after_write();
        int cyc;
        write_req(32'h200, 32'h12345678, 4'hF, 5, cyc);
        n_checks++;
        if (cyc !== 1) begin
            n_fail++;
            $display("FAIL raw_wack: got %0d cycles exp 1", cyc);
        end
        Core_Req_I  = 1'b1;
        Core_RW_I   = 1'b1;
        Core_Addr_I = 32'h200;
        Core_BE_I   = 4'hF;
        bus_serve("raw_wr", 32'h200, 32'h12345678, 4'hF, 1'b0, 0, 32'h0);
        n_checks++;
        if ({Bus_Req_O, Core_Ack_O} !== 2'b00) begin
            n_fail++;
            $display("FAIL raw_gap: got req=%b ack=%b exp 00", Bus_Req_O, Core_Ack_O);
        end
        bus_serve("raw_rd", 32'h200, 32'h0, 4'hF, 1'b1, 0, 32'hCAFEF00D);
        Core_Req_I = 1'b0;
        n_checks++;
        if ({Core_Ack_O, Core_BusErr_O, Core_Data_O} !== {2'b10, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL raw_rdata: got ack=%b berr=%b data=%h exp ack=1 berr=0 data=cafef00d",
                     Core_Ack_O, Core_BusErr_O, Core_Data_O);
        end
        @(negedge Clk);
        n_checks++;
        if (Core_Ack_O !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_pulse: got %b exp 0", Core_Ack_O);
        end
        wait_empty("raw");
    endtask

    task automatic test_read_latency();
        Core_Req_I  = 1'b1;
        Core_RW_I   = 1'b1;
        Core_Addr_I = 32'h300;
        Core_BE_I   = 4'h3;
        @(negedge Clk);
        n_checks++;
        if ({Bus_Req_O, Bus_RW_O, Bus_Addr_O, Bus_BE_O} !== {2'b11, 32'h300, 4'h3}) begin
            n_fail++;
            $display("FAIL lat_issue: got req=%b rw=%b addr=%h be=%h exp req=1 rw=1 addr=300 be=3",
                     Bus_Req_O, Bus_RW_O, Bus_Addr_O, Bus_BE_O);
        end
        Bus_Data_I = 32'h5A5A1234;
        Bus_Ack_I  = 1'b1;
        @(negedge Clk);
        Bus_Ack_I  = 1'b0;
        Core_Req_I = 1'b0;
        n_checks++;
        if ({Core_Ack_O, Core_Data_O} !== {1'b1, 32'h5A5A1234}) begin
            n_fail++;
            $display("FAIL lat_done: got ack=%b data=%h exp ack=1 data=5a5a1234", Core_Ack_O, Core_Data_O);
        end
        wait_empty("lat");
    endtask

    task automatic test_read_timeout();
        int hi;
        Bus_Data_I  = 32'hFFFFFFFF;
        Core_Req_I  = 1'b1;
        Core_RW_I   = 1'b1;
        Core_Addr_I = 32'h400;
        Core_BE_I   = 4'hF;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Bus_Req_O) hi++;
            else break;
        end
        Core_Req_I = 1'b0;
        n_checks++;
        if (hi !== 8) begin
            n_fail++;
            $display("FAIL rto_len: got %0d request cycles exp 8", hi);
        end
        n_checks++;
        if ({Core_Ack_O, Core_BusErr_O, Core_Data_O} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL rto_resp: got ack=%b berr=%b data=%h exp ack=1 berr=1 data=0",
                     Core_Ack_O, Core_BusErr_O, Core_Data_O);
        end
        @(negedge Clk);
        n_checks++;
        if ({Core_Ack_O, Core_BusErr_O} !== 2'b00) begin
            n_fail++;
            $display("FAIL rto_pulse: got ack=%b berr=%b exp 00", Core_Ack_O, Core_BusErr_O);
        end
        wait_empty("rto");
    endtask

    task automatic test_write_timeout();
        int cyc;
        int w;
        int hi;
        write_req(32'h500, 32'h55AA55AA, 4'hF, 5, cyc);
        w = 0;
        while (!Bus_Req_O && w < 5) begin
            @(negedge Clk);
            w++;
        end
        hi = 0;
        while (Bus_Req_O && hi < 20) begin
            hi++;
            @(negedge Clk);
        end
        n_checks++;
        if (hi !== 8) begin
            n_fail++;
            $display("FAIL wto_len: got %0d request cycles exp 8", hi);
        end
        n_checks++;
        if ({Wb_Err_O, Core_Ack_O} !== 2'b10) begin
            n_fail++;
            $display("FAIL wto_err: got err=%b ack=%b exp 10", Wb_Err_O, Core_Ack_O);
        end
        @(negedge Clk);
        n_checks++;
        if ({Wb_Empty_O, Wb_Err_O} !== 2'b11) begin
            n_fail++;
            $display("FAIL wto_popped: got empty=%b err=%b exp 11", Wb_Empty_O, Wb_Err_O);
        end
        Err_Clr_I = 1'b1;
        @(negedge Clk);
        Err_Clr_I = 1'b0;
        n_checks++;
        if (Wb_Err_O !== 1'b0) begin
            n_fail++;
            $display("FAIL wto_clr: got %b exp 0", Wb_Err_O);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bad;
        write_req(32'h600, 32'h00000001, 4'hF, 5, cyc);
        write_req(32'h604, 32'h00000002, 4'hF, 5, cyc);
        write_req(32'h608, 32'h00000003, 4'hF, 5, cyc);
        n_checks++;
        if ({Bus_Req_O, Wb_Empty_O} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_pre: got req=%b empty=%b exp 10", Bus_Req_O, Wb_Empty_O);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({Bus_Req_O, Wb_Empty_O, Core_Ack_O} !== 3'b010) begin
            n_fail++;
            $display("FAIL rst_async: got req=%b empty=%b ack=%b exp 010", Bus_Req_O, Wb_Empty_O, Core_Ack_O);
        end
        @(negedge Clk);
        Reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Bus_Req_O || Core_Ack_O || !Wb_Empty_O) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_quiet: got %0d active cycles after release exp 0", bad);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        Reset       = 1'b1;
        Core_Req_I  = 1'b0;
        Core_RW_I   = 1'b0;
        Core_Addr_I = '0;
        Core_Data_I = '0;
        Core_BE_I   = '0;
        Bus_Data_I  = '0;
        Bus_Ack_I   = 1'b0;
        Err_Clr_I   = 1'b0;

        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_after_write();
        test_read_latency();
        test_read_timeout();
        test_write_timeout();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
